// File: rtl/ddr4_v2_2_24_tg_data_chk.sv
// Traffic-generator read-data checker: prefetches expected words into a small FIFO,
// compares returned reads against the head and keeps sticky error status.
// Optional macro TG_CHK_FIRST_ERR_LOG_EN adds a capture of the first mismatching word.
module ddr4_v2_2_24_tg_data_chk #(
    parameter int APP_DATA_WIDTH = 288,
    parameter int FIFO_DEPTH     = 4,
    parameter int ERR_CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      chk_start,
    input  logic                      chk_stop,
    output logic                      gen_load,
    output logic                      gen_en,
    input  logic                      gen_valid,
    input  logic [APP_DATA_WIDTH-1:0] gen_data,
    input  logic                      rd_valid,
    input  logic [APP_DATA_WIDTH-1:0] rd_data,
    output logic                      err_any,
    output logic [APP_DATA_WIDTH-1:0] err_bits,
    output logic [ERR_CNT_WIDTH-1:0]  err_cnt,
    output logic [31:0]               word_cnt,
`ifdef TG_CHK_FIRST_ERR_LOG_EN
    output logic                      first_err_valid,
    output logic [APP_DATA_WIDTH-1:0] first_err_data,
    output logic [APP_DATA_WIDTH-1:0] first_err_exp,
    output logic [31:0]               first_err_idx,
`endif
    output logic                      underflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = AW + 1;
    localparam int CW = OW + 1;
    localparam int EW = ERR_CNT_WIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
    localparam logic [OW-1:0] OCC_ONE = OW'(1'b1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [EW-1:0] ERR_ONE = EW'(1'b1);
    localparam logic [EW-1:0] ERR_MAX = {EW{1'b1}};

    logic [1:0]                state_q, state_d;
    logic [OW-1:0]             occ_q, occ_d;
    logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
    logic                      gen_load_q, gen_load_d;
    logic                      gen_en_q, gen_en_d;
    logic                      gen_en_dly_q, gen_en_dly_d;
    logic                      s1_valid_q, s1_valid_d;
    logic [APP_DATA_WIDTH-1:0] s1_xor_q, s1_xor_d;
    logic                      err_any_q, err_any_d;
    logic [APP_DATA_WIDTH-1:0] err_bits_q, err_bits_d;
    logic [EW-1:0]             err_cnt_q, err_cnt_d;
    logic [31:0]               word_cnt_q, word_cnt_d;
    logic                      underflow_q, underflow_d;
`ifdef TG_CHK_FIRST_ERR_LOG_EN
    logic [APP_DATA_WIDTH-1:0] s1_rd_q, s1_rd_d;
    logic [APP_DATA_WIDTH-1:0] s1_exp_q, s1_exp_d;
    logic                      fe_valid_q, fe_valid_d;
    logic [APP_DATA_WIDTH-1:0] fe_data_q, fe_data_d;
    logic [APP_DATA_WIDTH-1:0] fe_exp_q, fe_exp_d;
    logic [31:0]               fe_idx_q, fe_idx_d;
`endif

    logic [APP_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic                      in_load_s;
    logic                      kill_s;
    logic                      fifo_empty_s;
    logic                      push_s;
    logic                      pop_s;
    logic                      mismatch_s;
    logic [APP_DATA_WIDTH-1:0] head_s;
    logic [CW-1:0]             req_sum_s;

    // Decode of the current cycle's FIFO events; LOAD hides stale entries.
    always_comb begin
        in_load_s    = (state_q == ST_LOAD);
        kill_s       = chk_start || in_load_s;
        fifo_empty_s = in_load_s || (occ_q == {OW{1'b0}});
        push_s       = gen_en_dly_q && gen_valid && !in_load_s;
        pop_s        = rd_valid && !fifo_empty_s;
        head_s       = mem_q[rd_ptr_q];
        mismatch_s   = |s1_xor_q;
    end

    // Control FSM; chk_start wins over chk_stop and over every state.
    always_comb begin
        state_d = state_q;
        if (chk_start) begin
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_LOAD: state_d = ST_RUN;
                ST_RUN: begin
                    if (chk_stop) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Pointer and occupancy bookkeeping; LOAD flushes.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (in_load_s) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            occ_d    = {OW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   occ_d = occ_q + OCC_ONE;
                2'b01:   occ_d = occ_q - OCC_ONE;
                default: occ_d = occ_q;
            endcase
        end
    end

    // Generator handshake. gen_en is precomputed from next-cycle state and
    // occupancy so the output comes straight from a flop; the current gen_en
    // is the request still in flight during the next cycle.
    always_comb begin
        gen_load_d   = chk_start;
        gen_en_dly_d = gen_en_q;
        req_sum_s    = CW'(occ_d) + CW'(gen_en_q);
        gen_en_d     = (state_d == ST_RUN) && (req_sum_s < DEPTH_C);
    end

    // Stage 1: register the per-bit difference of the popped word.
    always_comb begin
        s1_valid_d = pop_s && !kill_s;
        s1_xor_d   = rd_data ^ head_s;
`ifdef TG_CHK_FIRST_ERR_LOG_EN
        s1_rd_d    = rd_data;
        s1_exp_d   = head_s;
`endif
    end

    // Stage 2: sticky status; compares arriving with chk_start are dropped.
    always_comb begin
        err_any_d   = err_any_q;
        err_bits_d  = err_bits_q;
        err_cnt_d   = err_cnt_q;
        word_cnt_d  = word_cnt_q;
        underflow_d = underflow_q;
`ifdef TG_CHK_FIRST_ERR_LOG_EN
        fe_valid_d  = fe_valid_q;
        fe_data_d   = fe_data_q;
        fe_exp_d    = fe_exp_q;
        fe_idx_d    = fe_idx_q;
`endif
        if (in_load_s) begin
            err_any_d   = 1'b0;
            err_bits_d  = {APP_DATA_WIDTH{1'b0}};
            err_cnt_d   = {EW{1'b0}};
            word_cnt_d  = 32'd0;
            underflow_d = rd_valid;
`ifdef TG_CHK_FIRST_ERR_LOG_EN
            fe_valid_d  = 1'b0;
            fe_data_d   = {APP_DATA_WIDTH{1'b0}};
            fe_exp_d    = {APP_DATA_WIDTH{1'b0}};
            fe_idx_d    = 32'd0;
`endif
        end else begin
            if (rd_valid && fifo_empty_s) begin
                underflow_d = 1'b1;
            end else begin
                underflow_d = underflow_q;
            end
            if (s1_valid_q && !chk_start) begin
                word_cnt_d = word_cnt_q + 32'd1;
                if (mismatch_s) begin
                    err_any_d  = 1'b1;
                    err_bits_d = err_bits_q | s1_xor_q;
                    if (err_cnt_q != ERR_MAX) begin
                        err_cnt_d = err_cnt_q + ERR_ONE;
                    end else begin
                        err_cnt_d = err_cnt_q;
                    end
`ifdef TG_CHK_FIRST_ERR_LOG_EN
                    if (!fe_valid_q) begin
                        fe_valid_d = 1'b1;
                        fe_data_d  = s1_rd_q;
                        fe_exp_d   = s1_exp_q;
                        fe_idx_d   = word_cnt_q;
                    end else begin
                        fe_valid_d = fe_valid_q;
                    end
`endif
                end else begin
                    err_any_d = err_any_q;
                end
            end else begin
                word_cnt_d = word_cnt_q;
            end
        end
    end

    // Expected-word storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= gen_data;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            occ_q        <= {OW{1'b0}};
            wr_ptr_q     <= {AW{1'b0}};
            rd_ptr_q     <= {AW{1'b0}};
            gen_load_q   <= 1'b0;
            gen_en_q     <= 1'b0;
            gen_en_dly_q <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_xor_q     <= {APP_DATA_WIDTH{1'b0}};
            err_any_q    <= 1'b0;
            err_bits_q   <= {APP_DATA_WIDTH{1'b0}};
            err_cnt_q    <= {EW{1'b0}};
            word_cnt_q   <= 32'd0;
            underflow_q  <= 1'b0;
`ifdef TG_CHK_FIRST_ERR_LOG_EN
            s1_rd_q      <= {APP_DATA_WIDTH{1'b0}};
            s1_exp_q     <= {APP_DATA_WIDTH{1'b0}};
            fe_valid_q   <= 1'b0;
            fe_data_q    <= {APP_DATA_WIDTH{1'b0}};
            fe_exp_q     <= {APP_DATA_WIDTH{1'b0}};
            fe_idx_q     <= 32'd0;
`endif
        end else begin
            state_q      <= state_d;
            occ_q        <= occ_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            gen_load_q   <= gen_load_d;
            gen_en_q     <= gen_en_d;
            gen_en_dly_q <= gen_en_dly_d;
            s1_valid_q   <= s1_valid_d;
            s1_xor_q     <= s1_xor_d;
            err_any_q    <= err_any_d;
            err_bits_q   <= err_bits_d;
            err_cnt_q    <= err_cnt_d;
            word_cnt_q   <= word_cnt_d;
            underflow_q  <= underflow_d;
`ifdef TG_CHK_FIRST_ERR_LOG_EN
            s1_rd_q      <= s1_rd_d;
            s1_exp_q     <= s1_exp_d;
            fe_valid_q   <= fe_valid_d;
            fe_data_q    <= fe_data_d;
            fe_exp_q     <= fe_exp_d;
            fe_idx_q     <= fe_idx_d;
`endif
        end
    end

    assign gen_load  = gen_load_q;
    assign gen_en    = gen_en_q;
    assign err_any   = err_any_q;
    assign err_bits  = err_bits_q;
    assign err_cnt   = err_cnt_q;
    assign word_cnt  = word_cnt_q;
    assign underflow = underflow_q;
`ifdef TG_CHK_FIRST_ERR_LOG_EN
    assign first_err_valid = fe_valid_q;
    assign first_err_data  = fe_data_q;
    assign first_err_exp   = fe_exp_q;
    assign first_err_idx   = fe_idx_q;
`endif

endmodule

// File: tb/tb_ddr4_v2_2_24_tg_data_chk.sv
// Randomized bench for the TG read-data checker, scored against a queue-based
// reference model of the expected-word FIFO and the sticky status rules.
module tb_ddr4_v2_2_24_tg_data_chk;

    localparam int W  = 288;
    localparam int D  = 4;
    localparam int EW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          chk_start;
    logic          chk_stop;
    logic          gen_load;
    logic          gen_en;
    logic          gen_valid;
    logic [W-1:0]  gen_data;
    logic          rd_valid;
    logic [W-1:0]  rd_data;
    logic          err_any;
    logic [W-1:0]  err_bits;
    logic [EW-1:0] err_cnt;
    logic [31:0]   word_cnt;
    logic          underflow;
`ifdef TG_CHK_FIRST_ERR_LOG_EN
    logic          first_err_valid;
    logic [W-1:0]  first_err_data;
    logic [W-1:0]  first_err_exp;
    logic [31:0]   first_err_idx;
`endif

    always #5 clk = ~clk;

    ddr4_v2_2_24_tg_data_chk #(
        .APP_DATA_WIDTH (W),
        .FIFO_DEPTH     (D),
        .ERR_CNT_WIDTH  (EW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .chk_start (chk_start),
        .chk_stop  (chk_stop),
        .gen_load  (gen_load),
        .gen_en    (gen_en),
        .gen_valid (gen_valid),
        .gen_data  (gen_data),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .err_any   (err_any),
        .err_bits  (err_bits),
        .err_cnt   (err_cnt),
        .word_cnt  (word_cnt),
`ifdef TG_CHK_FIRST_ERR_LOG_EN
        .first_err_valid (first_err_valid),
        .first_err_data  (first_err_data),
        .first_err_exp   (first_err_exp),
        .first_err_idx   (first_err_idx),
`endif
        .underflow (underflow)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference model: 0 idle, 1 load, 2 run.
    int           m_state;
    logic [W-1:0] m_q [$];
    bit           m_en, m_en_prev;
    bit           m_err_any;
    logic [W-1:0] m_err_bits;
    int           m_err_cnt;
    logic [31:0]  m_word;
    bit           m_under;
    logic [W-1:0] p_rd [$];
    logic [W-1:0] p_exp [$];
    bit           m_fe_v;
    logic [W-1:0] m_fe_d, m_fe_e;
    logic [31:0]  m_fe_i;

    bit gen_seen = 1'b0;
    bit gen_drop_en = 1'b0;

    task automatic clear_status();
        m_err_any = 1'b0; m_err_bits = '0; m_err_cnt = 0; m_word = 32'd0; m_under = 1'b0;
        m_fe_v = 1'b0; m_fe_d = '0; m_fe_e = '0; m_fe_i = 32'd0;
        p_rd.delete(); p_exp.delete();
    endtask

    task automatic model_advance();
        bit is_load, kill, empty, push;
        logic [W-1:0] x, e;
        if (!rst) begin
            m_state = 0; m_q.delete(); m_en = 1'b0; m_en_prev = 1'b0;
            clear_status();
        end else begin
            is_load = (m_state == 1);
            kill    = chk_start || is_load;
            empty   = is_load || (m_q.size() == 0);
            push    = m_en_prev && gen_valid && !is_load;
            if (is_load) begin
                clear_status();
                m_under = rd_valid;
            end else begin
                if (!chk_start) begin
                    for (int i = 0; i < p_rd.size(); i++) begin
                        x = p_rd[i] ^ p_exp[i];
                        if (x != '0) begin
                            if (!m_fe_v) begin
                                m_fe_v = 1'b1; m_fe_d = p_rd[i]; m_fe_e = p_exp[i]; m_fe_i = m_word;
                            end
                            m_err_any  = 1'b1;
                            m_err_bits = m_err_bits | x;
                            if (m_err_cnt < (1 << EW) - 1) m_err_cnt++;
                        end
                        m_word = m_word + 32'd1;
                    end
                end
                p_rd.delete(); p_exp.delete();
                if (rd_valid && empty) m_under = 1'b1;
            end
            if (rd_valid && !empty) begin
                e = m_q.pop_front();
                if (!kill) begin
                    p_rd.push_back(rd_data);
                    p_exp.push_back(e);
                end
            end
            if (is_load) m_q.delete();
            else if (push) m_q.push_back(gen_data);
            if (chk_start) m_state = 1;
            else if (m_state == 1) m_state = 2;
            else if (m_state == 2 && chk_stop) m_state = 0;
            m_en_prev = m_en;
            m_en = (m_state == 2) && (m_q.size() + int'(m_en_prev) < D);
        end
    endtask

    task automatic compare_all();
        check_val("gen_load",  W'(gen_load),  W'(m_state == 1));
        check_val("gen_en",    W'(gen_en),    W'(m_en));
        check_val("err_any",   W'(err_any),   W'(m_err_any));
        check_val("err_bits",  err_bits,      m_err_bits);
        check_val("err_cnt",   W'(err_cnt),   W'(m_err_cnt));
        check_val("word_cnt",  W'(word_cnt),  W'(m_word));
        check_val("underflow", W'(underflow), W'(m_under));
`ifdef TG_CHK_FIRST_ERR_LOG_EN
        check_val("fe_valid", W'(first_err_valid), W'(m_fe_v));
        check_val("fe_data",  first_err_data,      m_fe_d);
        check_val("fe_exp",   first_err_exp,       m_fe_e);
        check_val("fe_idx",   W'(first_err_idx),   W'(m_fe_i));
`endif
    endtask

    // Generator stand-in: answers each gen_en one cycle later, with stray valids.
    task automatic drive_gen();
        bit fire;
        fire = gen_seen;
        gen_seen = gen_en;
        if (fire) gen_valid = gen_drop_en ? ($urandom % 16 != 0) : 1'b1;
        else gen_valid = ($urandom % 6 == 0);
        gen_data = rand_word();
    endtask

    task automatic step();
        @(posedge clk);
        model_advance();
        @(negedge clk);
        compare_all();
        drive_gen();
    endtask

    // Drive one read; matching data comes from the model's expected head.
    task automatic set_rd(input bit want, input bit corrupt, input int bitpos,
                          input bit allow_empty, output bit issued);
        bit avail;
        int b;
        avail = (m_state != 1) && (m_q.size() > 0);
        issued = 1'b0;
        rd_valid = 1'b0;
        rd_data = rand_word();
        if (want && avail) begin
            rd_valid = 1'b1;
            rd_data = m_q[0];
            b = (bitpos < 0) ? $urandom_range(W - 1) : bitpos;
            if (corrupt) rd_data[b] = ~rd_data[b];
            issued = 1'b1;
        end else if (want && allow_empty) begin
            rd_valid = 1'b1;
        end
    endtask

    task automatic start();
        chk_start = 1'b1;
        rd_valid = 1'b0;
        step();
        chk_start = 1'b0;
        check_val("start_gen_load", W'(gen_load), W'(1'b1));
    endtask

    task automatic run_words(input int n_words, input int err_mod, input int err_at,
                             input int bitpos, input bit every_cycle, output logic [W-1:0] exp_at);
        int n;
        bit iss, bad;
        n = 0;
        exp_at = '0;
        for (int c = 0; c < 4000 && n < n_words; c++) begin
            bad = (err_mod > 0 && (n % err_mod) == 0) || (n == err_at);
            if (n == err_at && m_q.size() > 0) exp_at = m_q[0];
            set_rd(every_cycle || ($urandom % 4 != 0), bad, bitpos, 1'b0, iss);
            if (iss) n++;
            step();
        end
        rd_valid = 1'b0;
        check_val("words_issued", W'(n), W'(n_words));
    endtask

    initial begin
        logic [W-1:0] bit5, exp10, dummy;
        int gl;
        bit iss;
        bit5 = '0;
        bit5[5] = 1'b1;
        rst = 1'b0; chk_start = 1'b0; chk_stop = 1'b0;
        rd_valid = 1'b0; rd_data = '0; gen_valid = 1'b0; gen_data = '0;
        repeat (3) step();
        check_val("rst_word_cnt", W'(word_cnt), W'(32'd0));
        check_val("rst_gen_en", W'(gen_en), W'(1'b0));
        rst = 1'b1;
        step();

        // Clean run
        start();
        run_words(100, 0, -1, 0, 1'b0, dummy);
        repeat (3) step();
        check_val("clean_word_cnt", W'(word_cnt), W'(32'd100));
        check_val("clean_err_any", W'(err_any), W'(1'b0));
        check_val("clean_err_cnt", W'(err_cnt), W'(4'd0));
        check_val("clean_underflow", W'(underflow), W'(1'b0));

        // Single-bit error on word 10
        start();
        run_words(20, 0, 10, 5, 1'b0, exp10);
        repeat (3) step();
        check_val("sbe_err_bits", err_bits, bit5);
        check_val("sbe_err_cnt", W'(err_cnt), W'(4'd1));
        check_val("sbe_err_any", W'(err_any), W'(1'b1));
`ifdef TG_CHK_FIRST_ERR_LOG_EN
        check_val("sbe_fe_idx", W'(first_err_idx), W'(32'd10));
        check_val("sbe_fe_exp", first_err_exp, exp10);
`endif

        // Underflow in LOAD and right after it (no bypass of the first push)
        chk_start = 1'b1;
        step();
        chk_start = 1'b0;
        rd_valid = 1'b1;
        rd_data = rand_word();
        step();
        check_val("uf_underflow", W'(underflow), W'(1'b1));
        check_val("uf_word_cnt", W'(word_cnt), W'(32'd0));
        repeat (2) step();
        rd_valid = 1'b0;
        repeat (3) step();
        check_val("uf_nobypass_word_cnt", W'(word_cnt), W'(32'd0));

        // Error counter saturation
        start();
        run_words(20, 1, -1, -1, 1'b0, dummy);
        repeat (3) step();
        check_val("sat_err_cnt", W'(err_cnt), W'(4'd15));
        check_val("sat_word_cnt", W'(word_cnt), W'(32'd20));

        // Backpressure then wrap
        start();
        repeat (10) step();
        check_val("bp_gen_en_low", W'(gen_en), W'(1'b0));
        check_val("bp_model_occ", W'(m_q.size()), W'(D));
        run_words(50, 0, -1, 0, 1'b1, dummy);
        repeat (3) step();
        check_val("wrap_word_cnt", W'(word_cnt), W'(32'd50));
        check_val("wrap_err_any", W'(err_any), W'(1'b0));

        // Restart with errors set and two compares in flight
        start();
        run_words(12, 3, -1, -1, 1'b0, dummy);
        set_rd(1'b1, 1'b1, -1, 1'b0, iss);
        step();
        set_rd(1'b1, 1'b1, -1, 1'b0, iss);
        chk_start = 1'b1;
        step();
        chk_start = 1'b0;
        rd_valid = 1'b0;
        gl = int'(gen_load);
        step();
        gl += int'(gen_load);
        check_val("rs_err_any", W'(err_any), W'(1'b0));
        check_val("rs_err_bits", err_bits, W'(1'b0));
        check_val("rs_err_cnt", W'(err_cnt), W'(4'd0));
        check_val("rs_word_cnt", W'(word_cnt), W'(32'd0));
        repeat (3) begin
            step();
            gl += int'(gen_load);
        end
        check_val("rs_err_any_held", W'(err_any), W'(1'b0));
        check_val("rs_gen_load_pulses", W'(gl), W'(1));

        // Reset mid-run with errors set and compares in flight
        run_words(8, 2, -1, -1, 1'b0, dummy);
        set_rd(1'b1, 1'b1, -1, 1'b0, iss);
        rst = 1'b0;
        step();
        check_val("mr_err_any", W'(err_any), W'(1'b0));
        check_val("mr_err_cnt", W'(err_cnt), W'(4'd0));
        check_val("mr_word_cnt", W'(word_cnt), W'(32'd0));
        check_val("mr_gen_en", W'(gen_en), W'(1'b0));
        rst = 1'b1;
        rd_valid = 1'b0;
        step();

        // Random traffic including stops, restarts, resets and underflows
        gen_drop_en = 1'b1;
        start();
        for (int c = 0; c < 3000; c++) begin
            set_rd($urandom % 2 == 0, $urandom % 10 == 0, -1, $urandom % 8 == 0, iss);
            chk_start = ($urandom % 200 == 0);
            chk_stop  = ($urandom % 150 == 0);
            rst       = ($urandom % 500 != 0);
            step();
        end
        rst = 1'b1; chk_start = 1'b0; chk_stop = 1'b0; rd_valid = 1'b0;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
